// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes and burst FSM states.
package usr_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ASR  = 3'd5,
    OP_LOAD = 3'd6,
    OP_CLR  = 3'd7
  } usr_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_bit_slice.sv
// One bit of the universal shift register: 8:1 next-state mux feeding an async-reset flop.
module usr_bit_slice
  import usr_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  usr_op_e op_i,
  input  logic    shr_in_i,
  input  logic    ror_in_i,
  input  logic    asr_in_i,
  input  logic    shl_in_i,
  input  logic    rol_in_i,
  input  logic    d_i,
  output logic    q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (op_i)
      OP_HOLD: q_d = q_q;
      OP_SHR:  q_d = shr_in_i;
      OP_SHL:  q_d = shl_in_i;
      OP_ROR:  q_d = ror_in_i;
      OP_ROL:  q_d = rol_in_i;
      OP_ASR:  q_d = asr_in_i;
      OP_LOAD: q_d = d_i;
      OP_CLR:  q_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= 1'b0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with single-step ops and a counted autonomous burst mode.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [N-1:0]     D,
  input  logic             SI_R,
  input  logic             SI_L,
  output logic [N-1:0]     Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(N);

  usr_state_e       state_q, state_d;
  usr_op_e          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  usr_op_e          op_live, eff_op;
  logic             is_shift;
  logic [CNT_W-1:0] len_sat;
  logic [N-1:0]     q;

  assign op_live  = usr_op_e'(op);
  assign is_shift = (op_live == OP_SHR) || (op_live == OP_SHL) || (op_live == OP_ROR) ||
                    (op_live == OP_ROL) || (op_live == OP_ASR);
  assign len_sat  = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;

  // A frozen cycle forces HOLD into every slice, so the datapath needs no separate enable.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eff_op  = OP_HOLD;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          eff_op = op_live;
          if (start) begin
            done_d = 1'b1;
            if (is_shift) begin
              if (len_sat == '0) begin
                eff_op = OP_HOLD;
              end else if (len_sat != CNT_W'(1)) begin
                done_d  = 1'b0;
                op_d    = op_live;
                cnt_d   = len_sat - CNT_W'(1);
                busy_d  = 1'b1;
                state_d = ST_BURST;
              end
            end
          end
        end
        ST_BURST: begin
          eff_op = op_q;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Edge slices take serial inputs or wrap-around bits; interior slices take neighbours.
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic shr_in, ror_in, asr_in, shl_in, rol_in;

    if (i == N - 1) begin : g_msb
      assign shr_in = SI_R;
      assign ror_in = q[0];
      assign asr_in = q[N-1];
    end else begin : g_hi
      assign shr_in = q[i+1];
      assign ror_in = q[i+1];
      assign asr_in = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign shl_in = SI_L;
      assign rol_in = q[N-1];
    end else begin : g_lo
      assign shl_in = q[i-1];
      assign rol_in = q[i-1];
    end

    usr_bit_slice u_slice (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .op_i     (eff_op),
      .shr_in_i (shr_in),
      .ror_in_i (ror_in),
      .asr_in_i (asr_in),
      .shl_in_i (shl_in),
      .rol_in_i (rol_in),
      .d_i      (D[i]),
      .q_o      (q[i])
    );
  end

  assign Q    = q;
  assign SO_R = q[0];
  assign SO_L = q[N-1];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised and directed bench for universal_shift_register (N=8) against an in-bench behavioural model.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [2:0]       op;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [N-1:0]     D;
  logic             SI_R, SI_L;
  logic [N-1:0]     Q;
  logic             SO_R, SO_L, busy, done;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  universal_shift_register #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .op        (op),
    .start     (start),
    .burst_len (burst_len),
    .D         (D),
    .SI_R      (SI_R),
    .SI_L      (SI_L),
    .Q         (Q),
    .SO_R      (SO_R),
    .SO_L      (SO_L),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural model: value after one operation, written as plain arithmetic.
  function automatic logic [7:0] f_apply(input logic [7:0] q, input logic [2:0] o,
                                         input logic sir, input logic sil, input logic [7:0] d);
    case (o)
      3'd1:    return (q >> 1) | (sir ? 8'h80 : 8'h00);
      3'd2:    return (q << 1) | {7'd0, sil};
      3'd3:    return (q >> 1) | ((q % 2 == 1) ? 8'h80 : 8'h00);
      3'd4:    return (q << 1) | ((q >= 8'h80) ? 8'h01 : 8'h00);
      3'd5:    return (q >> 1) | (q & 8'h80);
      3'd6:    return d;
      3'd7:    return 8'h00;
      default: return q;
    endcase
  endfunction

  function automatic int f_len(input logic [CNT_W-1:0] bl);
    return (int'(bl) > N) ? N : int'(bl);
  endfunction

  logic [7:0] m_q;
  int         m_rem;
  logic [2:0] m_op;
  logic       m_busy, m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= 8'h00; m_rem <= 0; m_op <= 3'd0; m_busy <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (en) begin
        if (m_rem != 0) begin
          m_q   <= f_apply(m_q, m_op, SI_R, SI_L, D);
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end else if (start && op >= 3'd1 && op <= 3'd5) begin
          if (f_len(burst_len) == 0) begin
            m_done <= 1'b1;
          end else begin
            m_q <= f_apply(m_q, op, SI_R, SI_L, D);
            if (f_len(burst_len) == 1) begin
              m_done <= 1'b1;
            end else begin
              m_rem  <= f_len(burst_len) - 1;
              m_busy <= 1'b1;
              m_op   <= op;
            end
          end
        end else begin
          m_q <= f_apply(m_q, op, SI_R, SI_L, D);
          if (start) m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({Q, busy, done, SO_R, SO_L} !== {m_q, m_busy, m_done, m_q[0], m_q[7]}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got Q=%h busy=%b done=%b SO_R=%b SO_L=%b required Q=%h busy=%b done=%b",
                 $time, Q, busy, done, SO_R, SO_L, m_q, m_busy, m_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    op = OP_LOAD; D = v; start = 1'b0; step();
  endtask

  task automatic single(input string nm, input logic [7:0] from, input logic [2:0] o,
                        input logic sir, input logic sil, input logic [7:0] exp);
    load(from);
    op = o; SI_R = sir; SI_L = sil; step();
    chk(nm, {24'd0, Q}, {24'd0, exp});
  endtask

  initial begin
    en = 1'b1; op = OP_HOLD; start = 1'b0; burst_len = '0; D = '0; SI_R = 1'b0; SI_L = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("reset_q", {24'd0, Q}, 32'h0);
    chk("reset_busy_done", {30'd0, busy, done}, 32'h0);
    #11 reset_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Reset mid-run, then load
    load(8'h3C);
    op = OP_SHL; SI_L = 1'b1; step(); step();
    reset_n = 1'b0;
    #1 chk("midrun_reset_q", {24'd0, Q}, 32'h0);
    chk("midrun_reset_flags", {28'd0, busy, done, SO_R, SO_L}, 32'h0);
    #1 reset_n = 1'b1;
    load(8'hA5);
    chk("load_a5", {24'd0, Q}, 32'hA5);
    chk("load_so", {30'd0, SO_R, SO_L}, 32'h3);

    // Single operations
    single("shr", 8'hA5, OP_SHR, 1'b0, 1'b0, 8'h52);
    single("shl", 8'hA5, OP_SHL, 1'b0, 1'b1, 8'h4B);
    single("ror", 8'hA5, OP_ROR, 1'b0, 1'b0, 8'hD2);
    single("rol", 8'hA5, OP_ROL, 1'b0, 1'b0, 8'h4B);
    single("asr", 8'h85, OP_ASR, 1'b0, 1'b0, 8'hC2);
    single("clr", 8'h85, OP_CLR, 1'b0, 1'b0, 8'h00);
    load(8'h3C);
    op = OP_HOLD;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold", {24'd0, Q}, 32'h3C);
    end

    // Burst rotate with op changed mid-burst
    load(8'h81);
    op = OP_ROL; start = 1'b1; burst_len = 4'd3; step();
    chk("rol_b1", {22'd0, Q, busy, done}, {22'd0, 8'h03, 2'b10});
    start = 1'b0; op = OP_CLR; step();
    chk("rol_b2", {22'd0, Q, busy, done}, {22'd0, 8'h06, 2'b10});
    step();
    chk("rol_b3", {22'd0, Q, busy, done}, {22'd0, 8'h0C, 2'b01});
    op = OP_HOLD; step();
    chk("rol_after", {22'd0, Q, busy, done}, {22'd0, 8'h0C, 2'b00});

    // burst_len 0 and 1
    op = OP_SHR; SI_R = 1'b0; start = 1'b1; burst_len = 4'd0; step();
    chk("len0", {22'd0, Q, busy, done}, {22'd0, 8'h0C, 2'b01});
    start = 1'b0; op = OP_HOLD; step();
    chk("len0_after", {31'd0, done}, 32'h0);
    op = OP_SHR; start = 1'b1; burst_len = 4'd1; step();
    chk("len1", {22'd0, Q, busy, done}, {22'd0, 8'h06, 2'b01});
    start = 1'b0; op = OP_HOLD; step();

    // Saturating length, start while busy ignored
    load(8'h00);
    op = OP_SHR; SI_R = 1'b1; start = 1'b1; burst_len = 4'd15; step();
    chk("sat_1", {22'd0, Q, busy, done}, {22'd0, 8'h80, 2'b10});
    start = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      logic [7:0] ev;
      if (k == 3) begin start = 1'b1; op = OP_SHL; burst_len = 4'd2; end
      if (k == 5) start = 1'b0;
      step();
      ev = 8'hFF << (8 - k);
      chk("sat_step", {22'd0, Q, busy, done}, {22'd0, ev, (k < 8), (k == 8)});
    end
    op = OP_HOLD; step();
    chk("sat_after", {22'd0, Q, busy, done}, {22'd0, 8'hFF, 2'b00});

    // Stall during SHL burst
    load(8'h01);
    op = OP_SHL; SI_L = 1'b0; start = 1'b1; burst_len = 4'd4; step();
    chk("stall_1", {24'd0, Q}, 32'h02);
    start = 1'b0; step();
    chk("stall_2", {24'd0, Q}, 32'h04);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_frozen", {22'd0, Q, busy, done}, {22'd0, 8'h04, 2'b10});
    end
    en = 1'b1; step();
    chk("stall_3", {22'd0, Q, busy, done}, {22'd0, 8'h08, 2'b10});
    step();
    chk("stall_4", {22'd0, Q, busy, done}, {22'd0, 8'h10, 2'b01});
    op = OP_HOLD; step();

    // Abort an ASR burst with reset, then a normal burst
    load(8'h80);
    op = OP_ASR; start = 1'b1; burst_len = 4'd6; step();
    chk("abort_1", {24'd0, Q}, 32'hC0);
    start = 1'b0; step();
    chk("abort_2", {24'd0, Q}, 32'hE0);
    reset_n = 1'b0;
    #1 chk("abort_now", {22'd0, Q, busy, done}, 32'h0);
    step();
    chk("abort_held", {22'd0, Q, busy, done}, 32'h0);
    reset_n = 1'b1; op = OP_HOLD; step();
    chk("abort_after", {22'd0, Q, busy, done}, 32'h0);
    load(8'hF0);
    op = OP_SHR; SI_R = 1'b0; start = 1'b1; burst_len = 4'd2; step();
    chk("post_abort_1", {22'd0, Q, busy, done}, {22'd0, 8'h78, 2'b10});
    start = 1'b0; step();
    chk("post_abort_2", {22'd0, Q, busy, done}, {22'd0, 8'h3C, 2'b01});
    op = OP_HOLD; step();

    // Random phase
    for (int c = 0; c < 800; c++) begin
      op        = 3'($urandom_range(0, 7));
      start     = ($urandom_range(0, 5) == 0);
      burst_len = CNT_W'($urandom_range(0, 15));
      D         = 8'($urandom);
      SI_R      = 1'($urandom);
      SI_L      = 1'($urandom);
      en        = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
